// File: rtl/fma_pkg.sv
// Shared types and constants for the FMA result stage: rounding modes,
// operand classes, flag bit positions and special-value encodings.
package fma_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RZ  = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } rmode_e;

  typedef enum logic [2:0] {
    CL_ZERO,
    CL_FINITE,
    CL_INF,
    CL_QNAN,
    CL_SNAN
  } fclass_e;

  localparam int FL_NV = 2;
  localparam int FL_OF = 1;
  localparam int FL_UF = 0;

  // Returned 64 bits wide; callers truncate to their word width.
  function automatic logic [63:0] canon_nan(input int ne, input int nf);
    return (((64'd1 << ne) - 64'd1) << nf) | (64'd1 << (nf - 1));
  endfunction

  function automatic logic [63:0] max_finite(input int ne, input int nf);
    return (((64'd1 << ne) - 64'd2) << nf) | ((64'd1 << nf) - 64'd1);
  endfunction

  function automatic logic cls_nan(input fclass_e c);
    return (c == CL_QNAN) || (c == CL_SNAN);
  endfunction

endpackage

// File: rtl/fma_classify.sv
// Decodes the magnitude bits of one floating-point operand into its class.
module fma_classify import fma_pkg::*; #(
  parameter int NE = 5,
  parameter int NF = 10
) (
  input  logic [NE+NF-1:0] mag_i,
  output fclass_e          cls_o
);

  logic [NE-1:0] e;
  logic [NF-1:0] f;

  assign e = mag_i[NE+NF-1:NF];
  assign f = mag_i[NF-1:0];

  always_comb begin
    if (&e)
      cls_o = (f == '0) ? CL_INF : (f[NF-1] ? CL_QNAN : CL_SNAN);
    else if ((e == '0) && (f == '0))
      cls_o = CL_ZERO;
    else
      cls_o = CL_FINITE;
  end

endmodule

// File: rtl/fma_result_stage.sv
// Two-stage result select for an FMA: resolves special values, overflow,
// underflow and exact-zero signs, and accumulates sticky exception flags.
module fma_result_stage import fma_pkg::*; #(
  parameter  int NE = 5,
  parameter  int NF = 10,
  localparam int W  = 1 + NE + NF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inValid,
  output logic         inReady,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  input  logic [W-1:0] prod,
  input  logic [W-1:0] sum,
  input  logic         mulOverflow,
  input  logic         addOverflow,
  input  logic         mulUnderflow,
  input  logic         sumZero,
  input  logic         mul,
  input  logic         add,
  input  logic [1:0]   roundMode,
  output logic         outValid,
  input  logic         outReady,
  output logic [W-1:0] result,
  output logic [2:0]   flags,
  input  logic         flagClr
);

  localparam logic [W-1:0] QNAN = W'(canon_nan(NE, NF));
  localparam logic [W-1:0] MAXF = W'(max_finite(NE, NF));
  localparam logic [W-1:0] INF  = {1'b0, {NE{1'b1}}, {NF{1'b0}}};

  fclass_e cx_d, cy_d, cz_d;
  fma_classify #(.NE(NE), .NF(NF)) u_cls_x (.mag_i(x[W-2:0]), .cls_o(cx_d));
  fma_classify #(.NE(NE), .NF(NF)) u_cls_y (.mag_i(y[W-2:0]), .cls_o(cy_d));
  fma_classify #(.NE(NE), .NF(NF)) u_cls_z (.mag_i(z[W-2:0]), .cls_o(cz_d));

  // Stage 1 state
  logic         s1Valid_q, s1Valid_d;
  logic [W-1:0] x_q, z_q, sum_q;
  logic         prodSign_q, mulOvf_q, addOvf_q, mulUdf_q, sumZero_q, mul_q, add_q;
  rmode_e       rm_q;
  fclass_e      cx_q, cy_q, cz_q;

  // Stage 2 state
  logic         s2Valid_q, s2Valid_d;
  logic [W-1:0] result_q, res_d;
  logic [2:0]   beatFl_q, fl_d, flags_q, flags_d;

  logic s1Load, s1Advance, s2Load, outHs;

  assign s2Load    = !s2Valid_q | outReady;
  assign s1Advance = s1Valid_q & s2Load;
  assign inReady   = !s1Valid_q | s1Advance;
  assign s1Load    = inValid & inReady;
  assign outHs     = s2Valid_q & outReady;
  assign s1Valid_d = s1Load | (s1Valid_q & !s1Advance);
  assign s2Valid_d = s2Load ? s1Valid_q : s2Valid_q;
  // A clear coinciding with a handshake still keeps the departing beat's flags.
  assign flags_d   = (flagClr ? 3'b000 : flags_q) | (outHs ? beatFl_q : 3'b000);

  assign outValid = s2Valid_q;
  assign result   = result_q;
  assign flags    = flags_q;

  logic         mulOnly, addOnly, ps, zs, ovf, pInf, pZero, anyNan, anySnan, toInf;
  fclass_e      cyE, czE;
  logic [W-1:0] zEff;

  always_comb begin
    mulOnly = mul_q & ~add_q;
    addOnly = ~mul_q & add_q;
    ps      = addOnly ? x_q[W-1] : prodSign_q;
    cyE     = addOnly ? CL_FINITE : cy_q;
    czE     = mulOnly ? CL_ZERO : cz_q;
    zEff    = mulOnly ? {ps, {(W-1){1'b0}}} : z_q;
    zs      = zEff[W-1];
    unique case ({mul_q, add_q})
      2'b10:   ovf = mulOvf_q;
      2'b01:   ovf = addOvf_q;
      2'b11:   ovf = addOvf_q | (mulOvf_q & mulUdf_q);
      default: ovf = 1'b0;
    endcase
    anyNan  = cls_nan(cx_q) | cls_nan(cyE) | cls_nan(czE);
    anySnan = (cx_q == CL_SNAN) | (cyE == CL_SNAN) | (czE == CL_SNAN);
    pInf    = (cx_q == CL_INF) | (cyE == CL_INF);
    pZero   = (cx_q == CL_ZERO) | (cyE == CL_ZERO);
    // Overflow rounds to infinity unless the mode rounds toward zero for this sign.
    toInf   = (rm_q == RM_RNE) | ((rm_q == RM_RDN) & ps) | ((rm_q == RM_RUP) & !ps);

    res_d = sum_q;
    fl_d  = 3'b000;
    if (!mul_q && !add_q) begin
      res_d = x_q;
    end else if (anyNan) begin
      res_d       = QNAN;
      fl_d[FL_NV] = anySnan;
    end else if ((pInf && pZero) || (pInf && (czE == CL_INF) && (zs != ps))) begin
      res_d       = QNAN;
      fl_d[FL_NV] = 1'b1;
    end else if (pInf) begin
      res_d = {ps, INF[W-2:0]};
    end else if (czE == CL_INF) begin
      res_d = zEff;
    end else if (ovf) begin
      res_d       = {ps, toInf ? INF[W-2:0] : MAXF[W-2:0]};
      fl_d[FL_OF] = 1'b1;
    end else if (mulUdf_q && (czE == CL_FINITE)) begin
      res_d       = (zs == ps) ? zEff : zEff - {{(W-1){1'b0}}, 1'b1};
      fl_d[FL_UF] = 1'b1;
    end else if (sumZero_q || (pZero && (czE == CL_ZERO))) begin
      res_d = {(zs != ps) ? (rm_q == RM_RDN) : ps, {(W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid_q <= 1'b0;
      s2Valid_q <= 1'b0;
      result_q  <= '0;
      beatFl_q  <= 3'b000;
      flags_q   <= 3'b000;
    end else begin
      s1Valid_q <= s1Valid_d;
      s2Valid_q <= s2Valid_d;
      flags_q   <= flags_d;
      if (s1Advance) begin
        result_q <= res_d;
        beatFl_q <= fl_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s1Load) begin
      x_q        <= x;
      z_q        <= z;
      sum_q      <= sum;
      prodSign_q <= prod[W-1];
      mulOvf_q   <= mulOverflow;
      addOvf_q   <= addOverflow;
      mulUdf_q   <= mulUnderflow;
      sumZero_q  <= sumZero;
      mul_q      <= mul;
      add_q      <= add;
      rm_q       <= rmode_e'(roundMode);
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      cz_q       <= cz_d;
    end
  end

endmodule

// File: tb/tb_fma_result_stage.sv
// Randomized bench for fma_result_stage with an in-bench value-level model
// and a queue scoreboard checked on every falling edge.
module tb_fma_result_stage;

  typedef struct {
    logic [15:0] x, y, z, prod, sum;
    logic        mo, ao, mu, sz, mul, add;
    logic [1:0]  rm;
  } beat_t;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  fl;
    int          c;
  } exp_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic        inValid = 1'b0, outReady = 1'b1, flagClr = 1'b0;
  logic        inReady, outValid;
  logic [15:0] result;
  logic [2:0]  flags;
  beat_t       cur = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

  int   errors = 0, checks = 0, cyc = 0, occ;
  bit   expOv, sawStall;
  logic [2:0] mflags = 3'b000;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  fma_result_stage dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .x(cur.x), .y(cur.y), .z(cur.z), .prod(cur.prod), .sum(cur.sum),
    .mulOverflow(cur.mo), .addOverflow(cur.ao), .mulUnderflow(cur.mu), .sumZero(cur.sz),
    .mul(cur.mul), .add(cur.add), .roundMode(cur.rm),
    .outValid(outValid), .outReady(outReady), .result(result), .flags(flags),
    .flagClr(flagClr)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic bit f_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'h0);
  endfunction
  function automatic bit f_snan(input logic [15:0] v);
    return f_nan(v) && !v[9];
  endfunction
  function automatic bit f_inf(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] == 10'h0);
  endfunction
  function automatic bit f_zero(input logic [15:0] v);
    return v[14:0] == 15'h0;
  endfunction

  // Value-level reference: substitute the implied operands, then apply the rules in priority order.
  function automatic exp_t ref_beat(input beat_t b);
    exp_t r;
    logic [15:0] yv, zv;
    logic ps, zs, ovf;
    r.res = b.sum; r.fl = 3'b000; r.c = 0;
    if (!b.mul && !b.add) begin
      r.res = b.x;
      return r;
    end
    yv  = b.mul ? b.y : 16'h3C00;
    ps  = b.mul ? b.prod[15] : b.x[15];
    zv  = b.add ? b.z : {ps, 15'h0};
    zs  = zv[15];
    ovf = (b.mul && b.add) ? (b.ao | (b.mo & b.mu)) : (b.mul ? b.mo : b.ao);
    if (f_nan(b.x) || f_nan(yv) || f_nan(zv)) begin
      r.res = 16'h7E00;
      r.fl  = {f_snan(b.x) | f_snan(yv) | f_snan(zv), 2'b00};
    end else if ((f_inf(b.x) && f_zero(yv)) || (f_zero(b.x) && f_inf(yv))) begin
      r.res = 16'h7E00; r.fl = 3'b100;
    end else if ((f_inf(b.x) || f_inf(yv)) && f_inf(zv) && (zs != ps)) begin
      r.res = 16'h7E00; r.fl = 3'b100;
    end else if (f_inf(b.x) || f_inf(yv)) begin
      r.res = ps ? 16'hFC00 : 16'h7C00;
    end else if (f_inf(zv)) begin
      r.res = zv;
    end else if (ovf) begin
      r.fl = 3'b010;
      case (b.rm)
        2'd0:    r.res = ps ? 16'hFC00 : 16'h7C00;
        2'd1:    r.res = ps ? 16'hFBFF : 16'h7BFF;
        2'd2:    r.res = ps ? 16'hFC00 : 16'h7BFF;
        default: r.res = ps ? 16'hFBFF : 16'h7C00;
      endcase
    end else if (b.mu && !f_zero(zv)) begin
      r.fl  = 3'b001;
      r.res = (zs == ps) ? zv : zv - 16'd1;
    end else if (b.sz || ((f_zero(b.x) || f_zero(yv)) && f_zero(zv))) begin
      r.res = (zs != ps) ? ((b.rm == 2'd2) ? 16'h8000 : 16'h0000) : {ps, 15'h0};
    end
    return r;
  endfunction

  function automatic beat_t mk(input logic [15:0] x, y, z, prod, sum,
                               input logic mo, ao, mu, sz, mul, add, input logic [1:0] rm);
    beat_t b;
    b.x = x; b.y = y; b.z = z; b.prod = prod; b.sum = sum;
    b.mo = mo; b.ao = ao; b.mu = mu; b.sz = sz; b.mul = mul; b.add = add; b.rm = rm;
    return b;
  endfunction

  function automatic logic [15:0] rval();
    case ($urandom_range(0, 13))
      0: return 16'h0000;  1: return 16'h8000;  2: return 16'h7C00;  3: return 16'hFC00;
      4: return 16'h7E00;  5: return 16'h7D01;  6: return 16'h3C00;  7: return 16'hBC00;
      8: return 16'h0001;  9: return 16'h7BFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic beat_t rbeat();
    return mk(rval(), rval(), rval(), rval(), 16'($urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              1'($urandom), 1'($urandom), 2'($urandom));
  endfunction

  // Scoreboard: a beat accepted at falling edge c sits in the output register from c+2 on.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      mflags = 3'b000;
    end else begin
      occ   = q.size();
      expOv = (occ > 0) && (cyc >= q[0].c + 2);
      check("inReady", inReady, (occ < 2) || outReady);
      check("outValid", outValid, expOv);
      check("flags", flags, mflags);
      if (expOv) check("result", result, q[0].res);
      if (inValid && !inReady) sawStall = 1'b1;
      if (inValid && inReady) begin
        e = ref_beat(cur);
        e.c = cyc;
        q.push_back(e);
      end
      if (expOv && outReady) begin
        mflags = (flagClr ? 3'b000 : mflags) | q[0].fl;
        void'(q.pop_front());
      end else if (flagClr) begin
        mflags = 3'b000;
      end
    end
  end

  task automatic send(input beat_t b);
    bit done = 1'b0;
    cur = b;
    inValid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = inReady;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    check("send_accept", done, 1'b1);
  endtask

  task automatic wait_empty();
    bit empty = 1'b0;
    for (int n = 0; n < 100 && !empty; n++) begin
      @(negedge clk);
      empty = (q.size() == 0);
    end
    @(posedge clk); #1;
    check("drain", empty, 1'b1);
  endtask

  beat_t pins[12];
  logic [18:0] pinWant[12];

  initial begin
    pins[0]  = mk(16'h3C00, 16'h4000, 16'h3C00, 16'h4000, 16'h4200, 0, 0, 0, 0, 1, 1, 2'd0);
    pinWant[0] = {3'b000, 16'h4200};
    pins[1]  = mk(16'h3C00, 16'h3C00, 16'h3C00, 16'hFC00, 16'h1234, 1, 1, 0, 0, 1, 1, 2'd1);
    pinWant[1] = {3'b010, 16'hFBFF};
    pins[2]  = mk(16'h3C00, 16'h3C00, 16'h3C00, 16'hFC00, 16'h1234, 1, 1, 0, 0, 1, 1, 2'd0);
    pinWant[2] = {3'b010, 16'hFC00};
    pins[3]  = mk(16'h3C00, 16'h3C00, 16'h3C00, 16'hFC00, 16'h1234, 1, 1, 0, 0, 1, 1, 2'd3);
    pinWant[3] = {3'b010, 16'hFBFF};
    pins[4]  = mk(16'h7C00, 16'h0000, 16'h3C00, 16'h7C00, 16'h1234, 0, 0, 0, 0, 1, 1, 2'd0);
    pinWant[4] = {3'b100, 16'h7E00};
    pins[5]  = mk(16'h7C00, 16'h3C00, 16'hFC00, 16'h7C00, 16'h1234, 0, 0, 0, 0, 1, 1, 2'd0);
    pinWant[5] = {3'b100, 16'h7E00};
    pins[6]  = mk(16'h8000, 16'h3C00, 16'h0000, 16'h8000, 16'h1111, 0, 0, 0, 0, 1, 1, 2'd0);
    pinWant[6] = {3'b000, 16'h0000};
    pins[7]  = mk(16'h8000, 16'h3C00, 16'h0000, 16'h8000, 16'h1111, 0, 0, 0, 0, 1, 1, 2'd2);
    pinWant[7] = {3'b000, 16'h8000};
    pins[8]  = mk(16'h0400, 16'h0400, 16'hBC00, 16'h0000, 16'h1111, 0, 0, 1, 0, 1, 1, 2'd0);
    pinWant[8] = {3'b001, 16'hBBFF};
    pins[9]  = mk(16'h7D01, 16'h3C00, 16'h3C00, 16'h3C00, 16'h1111, 0, 0, 0, 0, 0, 0, 2'd0);
    pinWant[9] = {3'b000, 16'h7D01};
    pins[10] = mk(16'h3C00, 16'h7D01, 16'h3C00, 16'h3C00, 16'h1111, 0, 0, 0, 0, 1, 0, 2'd0);
    pinWant[10] = {3'b100, 16'h7E00};
    pins[11] = mk(16'h4000, 16'h1234, 16'h7C00, 16'h4000, 16'h1111, 0, 0, 0, 0, 0, 1, 2'd0);
    pinWant[11] = {3'b000, 16'h7C00};

    for (int i = 0; i < 12; i++) begin
      e = ref_beat(pins[i]);
      check($sformatf("pin%0d", i), {e.fl, e.res}, pinWant[i]);
    end

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_result", result, 16'h0000);
    check("rst_inReady", inReady, 1'b1);
    check("rst_outValid", outValid, 1'b0);
    check("rst_flags", flags, 3'b000);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) send(pins[i]);
    wait_empty();

    // Backpressure: four beats against a three-cycle output stall.
    sawStall = 1'b0;
    outReady = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(rbeat());
      end
      begin
        repeat (3) @(posedge clk);
        #1 outReady = 1'b1;
      end
    join
    wait_empty();
    check("bp_stall_seen", sawStall, 1'b1);

    // Clear coinciding with an overflow beat's handshake keeps only OF.
    outReady = 1'b0;
    send(pins[1]);
    for (int n = 0; n < 20 && !outValid; n++) @(negedge clk);
    check("clr_outValid", outValid, 1'b1);
    @(posedge clk); #1;
    flagClr = 1'b1;
    outReady = 1'b1;
    @(posedge clk); #1;
    flagClr = 1'b0;
    check("clr_with_hs", flags, 3'b010);

    for (int n = 0; n < 1500; n++) begin
      cur      = rbeat();
      inValid  = $urandom_range(0, 9) < 7;
      outReady = $urandom_range(0, 9) < 7;
      flagClr  = $urandom_range(0, 19) == 0;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    flagClr = 1'b0;
    outReady = 1'b1;
    wait_empty();

    // Reset with both stages full.
    send(pins[1]);
    wait_empty();
    outReady = 1'b0;
    inValid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cur = rbeat();
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    check("r2_outValid", outValid, 1'b0);
    check("r2_flags", flags, 3'b000);
    check("r2_inReady", inReady, 1'b1);
    check("r2_result", result, 16'h0000);
    @(posedge clk); #1;

    send(pins[0]);
    send(pins[8]);
    wait_empty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
